// File: rtl/matrix_stream_loader_if.sv
// Signal bundle between the element stream / matrix calculator and matrix_stream_loader.
// The loader uses the slave view; the stream source and calculator side use the master view.
interface matrix_stream_loader_if #(
    parameter int DATA_W = 32,
    parameter int N_ELEM = 16
);
    logic [DATA_W-1:0]        s_data;
    logic                     s_valid;
    logic                     s_last;
    logic                     s_ready;
    logic [3:0]               command;
    logic [DATA_W*N_ELEM-1:0] Matrix_in;
    logic                     done;
    logic                     frame_err;
    logic                     busy;

    modport master (
        output s_data, s_valid, s_last,
        input  s_ready, command, Matrix_in, done, frame_err, busy
    );

    modport slave (
        input  s_data, s_valid, s_last,
        output s_ready, command, Matrix_in, done, frame_err, busy
    );
endinterface

// File: rtl/matrix_stream_loader.sv
// Packs a 32-bit element stream into 4x4 matrices and sequences IN/CALC/OUT commands per job.
// Optional macro MSL_TRANSPOSE_EN stores matrix B transposed (column-major stream -> row-major bus).
module matrix_stream_loader #(
    parameter int         DATA_W      = 32,
    parameter int         N_ELEM      = 16,
    parameter int         CALC_CYCLES = 2,
    parameter logic [3:0] CMD_IDLE    = 4'd0,
    parameter logic [3:0] CMD_IN      = 4'd1,
    parameter logic [3:0] CMD_CALC    = 4'd2,
    parameter logic [3:0] CMD_OUT     = 4'd3
) (
    input  logic                  CLK,
    input  logic                  reset,
    matrix_stream_loader_if.slave bus
);
    localparam int IDX_W = $clog2(N_ELEM);
    localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

    typedef enum logic [2:0] {
        FILL_A,
        LOAD,
        FILL_B,
        CALC,
        OUT
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  idx_next;
    logic [CNT_W-1:0]  calc_cnt_reg;
    logic [CNT_W-1:0]  calc_cnt_next;
    logic              frame_err_reg;
    logic              frame_err_next;
    logic [3:0]        command_reg;
    logic [3:0]        command_next;
    logic              s_ready_reg;
    logic              done_reg;
    logic              busy_reg;

    logic              xfer;
    logic              last_slot;
    logic              misframed;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_slot;
    logic [DATA_W*N_ELEM-1:0] buffer;

    assign xfer      = bus.s_valid && s_ready_reg;
    assign last_slot = (idx_reg == IDX_W'(N_ELEM - 1));
    // An early s_last aborts the current matrix; that element is dropped.
    assign misframed = xfer && bus.s_last && !last_slot;
    assign wr_en     = xfer && !misframed;

`ifdef MSL_TRANSPOSE_EN
    localparam int SIDE = 4;
    logic [IDX_W-1:0] slot_t;

    assign slot_t  = IDX_W'((int'(idx_reg) % SIDE) * SIDE + int'(idx_reg) / SIDE);
    assign wr_slot = (state_reg == FILL_B) ? slot_t : idx_reg;
`else
    assign wr_slot = idx_reg;
`endif

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        calc_cnt_next  = calc_cnt_reg;
        frame_err_next = frame_err_reg;
        command_next   = CMD_IDLE;

        case (state_reg)
            FILL_A, FILL_B: begin
                if (misframed) begin
                    frame_err_next = 1'b1;
                    idx_next       = '0;
                end else if (xfer) begin
                    if (last_slot) begin
                        idx_next   = '0;
                        state_next = (state_reg == FILL_A) ? LOAD : CALC;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            LOAD: begin
                state_next = FILL_B;
            end
            CALC: begin
                if (calc_cnt_reg == CNT_W'(CALC_CYCLES - 1)) begin
                    calc_cnt_next = '0;
                    state_next    = OUT;
                end else begin
                    calc_cnt_next = calc_cnt_reg + 1'b1;
                end
            end
            OUT: begin
                state_next = FILL_A;
            end
            default: begin
                state_next = FILL_A;
                idx_next   = '0;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up with it.
        case (state_next)
            LOAD:    command_next = CMD_IN;
            CALC:    command_next = CMD_CALC;
            OUT:     command_next = CMD_OUT;
            default: command_next = CMD_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg     <= FILL_A;
            idx_reg       <= '0;
            calc_cnt_reg  <= '0;
            frame_err_reg <= 1'b0;
            command_reg   <= CMD_IDLE;
            s_ready_reg   <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            calc_cnt_reg  <= calc_cnt_next;
            frame_err_reg <= frame_err_next;
            command_reg   <= command_next;
            s_ready_reg   <= (state_next == FILL_A) || (state_next == FILL_B);
            done_reg      <= (state_next == OUT);
            busy_reg      <= !((state_next == FILL_A) && (idx_next == '0));
        end
    end

    // One holding register per matrix slot; the whole set drives the bus continuously.
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_slot
        logic [DATA_W-1:0] word_reg;

        always_ff @(posedge CLK or negedge reset) begin
            if (!reset) begin
                word_reg <= '0;
            end else if (wr_en && (wr_slot == IDX_W'(gi))) begin
                word_reg <= bus.s_data;
            end
        end

        assign buffer[gi*DATA_W +: DATA_W] = word_reg;
    end

    assign bus.Matrix_in = buffer;
    assign bus.s_ready   = s_ready_reg;
    assign bus.command   = command_reg;
    assign bus.done      = done_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Self-checking bench for matrix_stream_loader: directed job table, random jobs against a
// transaction-level model, and an asynchronous reset taken in the middle of CALC.
module tb_matrix_stream_loader;
    localparam int         CALC_CYCLES = 2;
    localparam logic [3:0] C_IDLE = 4'd0;
    localparam logic [3:0] C_IN   = 4'd1;
    localparam logic [3:0] C_CALC = 4'd2;
    localparam logic [3:0] C_OUT  = 4'd3;
`ifdef MSL_TRANSPOSE_EN
    localparam bit TR_B = 1'b1;
`else
    localparam bit TR_B = 1'b0;
`endif

    logic CLK = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    matrix_stream_loader_if #(.DATA_W(32), .N_ELEM(16)) bus ();

    matrix_stream_loader dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: accepted words, pending calculator commands.
    logic [31:0]  cur[$];
    logic [3:0]   cmd_q[$];
    bit           phase_b;
    bit           ferr_m;
    bit           just_reset;
    logic [3:0]   prev_cmd;
    logic [511:0] a_m;
    logic [511:0] b_m;
    int           xfers_since_done;

    // Per-job observations for the table spot checks.
    logic [511:0] load_mat;
    logic [511:0] calc_mat;
    int           calc_seen;
    int           done_seen;
    int           load_gap;

    typedef struct {
        int          gap;
        int          err_pos;
        logic [31:0] a_base;
        logic [31:0] b_base;
        bit          drop_last;
        logic [31:0] e_a0;
        logic [31:0] e_a15;
        logic [31:0] e_b0;
        logic [31:0] e_b15;
        logic [31:0] e_b1;
        logic [31:0] e_b4;
        bit          e_ferr;
        int          e_gap;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [511:0] pack(input logic [31:0] w[$], input bit transpose);
        logic [511:0] m;
        int slot;
        m = '0;
        for (int k = 0; k < 16; k++) begin
            slot = transpose ? (k % 4) * 4 + k / 4 : k;
            m[slot*32 +: 32] = w[k];
        end
        return m;
    endfunction

    task automatic model_reset();
        cur.delete();
        cmd_q.delete();
        phase_b          = 1'b0;
        ferr_m           = 1'b0;
        just_reset       = 1'b1;
        prev_cmd         = C_IDLE;
        xfers_since_done = 0;
    endtask

    // One clock cycle: drive at the falling edge, check just after the rising edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l, output bit xfer);
        logic [3:0] cmd_now;
        logic       rdy;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
        #1;
        rdy = bus.s_ready;
        chk("s_ready", rdy, (prev_cmd == C_IDLE) && !just_reset);
        @(posedge CLK);
        #1;
        just_reset = 1'b0;
        xfer = v && rdy;
        if (xfer) begin
            xfers_since_done++;
            if (l && cur.size() < 15) begin
                ferr_m = 1'b1;
                cur.delete();
            end else begin
                cur.push_back(d);
                if (cur.size() == 16) begin
                    if (!phase_b) begin
                        a_m = pack(cur, 1'b0);
                        cmd_q.push_back(C_IN);
                    end else begin
                        b_m = pack(cur, TR_B);
                        repeat (CALC_CYCLES) cmd_q.push_back(C_CALC);
                        cmd_q.push_back(C_OUT);
                    end
                    phase_b = !phase_b;
                    cur.delete();
                end
            end
        end
        cmd_now = (cmd_q.size() > 0) ? cmd_q.pop_front() : C_IDLE;
        chk("command", bus.command, cmd_now);
        chk("done", bus.done, cmd_now == C_OUT);
        chk("frame_err", bus.frame_err, ferr_m);
        chk("busy", bus.busy, !(cmd_now == C_IDLE && !phase_b && cur.size() == 0));
        if (cmd_now == C_IN)   chk("Matrix_in_load", bus.Matrix_in, a_m);
        if (cmd_now == C_CALC) chk("Matrix_in_calc", bus.Matrix_in, b_m);
        if (bus.command == C_IN) begin
            load_mat = bus.Matrix_in;
            load_gap = xfers_since_done;
        end
        if (bus.command == C_CALC) begin
            calc_mat = bus.Matrix_in;
            calc_seen++;
        end
        if (bus.done) done_seen++;
        if (cmd_now == C_OUT) xfers_since_done = 0;
        prev_cmd = cmd_now;
        @(negedge CLK);
    endtask

    task automatic run_job(input int gap, input int err_pos, input logic [31:0] a_base,
                           input logic [31:0] b_base, input bit rnd, input bit drop_last);
        logic [31:0] wd[$];
        bit          wl[$];
        bit          x;
        bit          v;
        int          i;
        int          guard;
        for (int p = 0; p < err_pos; p++) begin
            wd.push_back(32'h900 + 32'(p));
            wl.push_back(p == err_pos - 1);
        end
        for (int k = 0; k < 32; k++) begin
            wd.push_back(rnd ? $urandom : (k < 16 ? a_base + 32'(k) : b_base + 32'(k - 16)));
            wl.push_back((k == 15 || k == 31) && !(drop_last && k == 15));
        end
        load_mat  = '0;
        calc_mat  = '0;
        calc_seen = 0;
        done_seen = 0;
        load_gap  = -1;
        i = 0;
        guard = 0;
        while (i < wd.size()) begin
            v = ($urandom_range(99) >= gap);
            cycle(v, v ? wd[i] : $urandom, v ? logic'(wl[i]) : logic'($urandom_range(1)), x);
            if (x) i++;
            guard++;
            if (guard > 3000) begin
                chk("stream_timeout", 512'(i), 512'(wd.size()));
                break;
            end
        end
        guard = 0;
        while (done_seen == 0 && guard < 20) begin
            cycle(gap == 0, $urandom, 1'b0, x);
            guard++;
        end
        chk("done_seen", 512'(done_seen), 512'd1);
        chk("calc_cycles", 512'(calc_seen), 512'(CALC_CYCLES));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit x;
        int guard;
        int acc;

        tbl[0] = '{0,  0, 32'd0,   32'd16,  1'b0, 32'd0,   32'd15,  32'd16,  32'd31,
                   TR_B ? 32'd20 : 32'd17,   TR_B ? 32'd17 : 32'd20,   1'b0, 16};
        tbl[1] = '{50, 0, 32'd0,   32'd16,  1'b0, 32'd0,   32'd15,  32'd16,  32'd31,
                   TR_B ? 32'd20 : 32'd17,   TR_B ? 32'd17 : 32'd20,   1'b0, 16};
        tbl[2] = '{0,  6, 32'd100, 32'd16,  1'b0, 32'd100, 32'd115, 32'd16,  32'd31,
                   TR_B ? 32'd20 : 32'd17,   TR_B ? 32'd17 : 32'd20,   1'b1, 22};
        tbl[3] = '{30, 0, 32'd200, 32'd300, 1'b1, 32'd200, 32'd215, 32'd300, 32'd315,
                   TR_B ? 32'd304 : 32'd301, TR_B ? 32'd301 : 32'd304, 1'b1, 16};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_command", bus.command, C_IDLE);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_frame_err", bus.frame_err, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_Matrix_in", bus.Matrix_in, '0);
        reset = 1'b1;
        model_reset();

        // Directed jobs, run back-to-back.
        for (int t = 0; t < 4; t++) begin
            run_job(tbl[t].gap, tbl[t].err_pos, tbl[t].a_base, tbl[t].b_base, 1'b0, tbl[t].drop_last);
            chk("tbl_load_a0",  load_mat[31:0],    tbl[t].e_a0);
            chk("tbl_load_a15", load_mat[511:480], tbl[t].e_a15);
            chk("tbl_calc_b0",  calc_mat[31:0],    tbl[t].e_b0);
            chk("tbl_calc_b15", calc_mat[511:480], tbl[t].e_b15);
            chk("tbl_calc_s1",  calc_mat[63:32],   tbl[t].e_b1);
            chk("tbl_calc_s4",  calc_mat[159:128], tbl[t].e_b4);
            chk("tbl_frame_err", bus.frame_err,    tbl[t].e_ferr);
            chk("tbl_load_gap", 512'(load_gap),    512'(tbl[t].e_gap));
            $display("job %0d: A0=%0d B0=%0d ferr=%0b xfers_to_load=%0d", t,
                     load_mat[31:0], calc_mat[31:0], bus.frame_err, load_gap);
        end

        // Random jobs: random data, gaps, early s_last and missing final s_last.
        for (int r = 0; r < 6; r++) begin
            int ep;
            ep = ($urandom_range(3) == 0) ? int'($urandom_range(15, 1)) : 0;
            run_job(int'($urandom_range(70)), ep, 32'd0, 32'd0, 1'b1, bit'($urandom_range(1)));
            $display("rnd job %0d: early_last_at=%0d A0=%0h B0=%0h", r, ep, load_mat[31:0], calc_mat[31:0]);
        end

        // Stream a job up to CALC, then pull reset asynchronously between clock edges.
        acc = 0;
        guard = 0;
        while (acc < 32 && guard < 200) begin
            cycle(1'b1, 32'(acc), (acc == 15 || acc == 31), x);
            if (x) acc++;
            guard++;
        end
        chk("pre_reset_calc", bus.command, C_CALC);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_command", bus.command, C_IDLE);
        chk("async_rst_busy", bus.busy, 1'b0);
        chk("async_rst_frame_err", bus.frame_err, 1'b0);
        chk("async_rst_s_ready", bus.s_ready, 1'b0);
        chk("async_rst_done", bus.done, 1'b0);
        @(negedge CLK);
        reset = 1'b1;
        model_reset();
        run_job(0, 0, 32'h55, 32'h80, 1'b0, 1'b0);
        chk("post_rst_load_a0", load_mat[31:0], 32'h55);
        chk("post_rst_frame_err", bus.frame_err, 1'b0);
        $display("reset job: A0=%0h B0=%0h", load_mat[31:0], calc_mat[31:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
